clkdiv_multi: RTL and testbench
===============================

# clkdiv_multi

Multi-channel programmable clock-enable generator with per-channel busy-cycle counters. It replaces the fixed divide-by-4 divider. Each channel produces a single-cycle `tick` enable and a 50 %-duty `clk_div` level at a runtime-programmable ratio. Everything runs in the `clk` domain: downstream logic uses `tick` as a clock enable, and no derived clock is used as an edge source. The block sits between the system clock and the processor's slow-rate units (display refresh, UART baud, cycle profiling).

## Interface
- `NCH`, 2: number of independent channels
- `DIV_W`, 16: width of each divide ratio
- `CNT_W`, 32: width of each busy-cycle counter
- `DEFAULT_DIV`, 4: ratio loaded at reset
- `clk` in 1: system clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `en` in NCH: per-channel count enable
- `div_ratio` in NCH*DIV_W: requested ratio R per channel; channel i is bits [i*DIV_W +: DIV_W]
- `load` in 1: synchronous restart of all channels, which also captures `div_ratio`
- `busy` in NCH: per-channel "count this tick" qualifier
- `cnt_clr` in 1: synchronous clear of all counters and saturation flags
- `tick` out NCH: one-cycle pulse, once every R enabled cycles
- `clk_div` out NCH: level output that toggles on each tick, period 2R enabled cycles
- `clkcount` out NCH*CNT_W: number of ticks seen while `busy` was high
- `cnt_sat` out NCH: sticky flag, set when `clkcount` is pinned at all-ones

## Operation
- **Per-channel state:** phase counter `ph` (DIV_W bits), shadow ratio `rs`, `tick`, `clk_div`, `clkcount`, `cnt_sat`.
- **Effective ratio:** Re = (rs == 0) ? 1 : rs.
- **Priority each edge:** `load` > `en` > hold.
- **`load` = 1:**
  - `ph` <= 0, `tick` <= 0, `clk_div` <= 0, `rs` <= `div_ratio` slice.
  - Counters are untouched.
- **`en` = 1:**
  - If `ph` == Re-1: `ph` <= 0, `tick` <= 1, `clk_div` <= ~`clk_div`, `rs` <= `div_ratio` slice.
  - Otherwise: `ph` <= `ph`+1, `tick` <= 0.
  - The ratio is re-sampled only at the terminal count, so a new ratio never truncates a period in progress.
- **`en` = 0:** `ph`, `clk_div`, `rs` hold; `tick` <= 0.
- **Re = 1:** `tick` stays high on every enabled cycle; `clk_div` toggles every enabled cycle.
- **Counter update:**
  - If `cnt_clr`: `clkcount` <= 0, `cnt_sat` <= 0. Clear wins over a simultaneous increment.
  - Else if `tick` && `busy` (registered `tick`, current `busy`):
    - At all-ones, the value holds and `cnt_sat` <= 1.
    - Otherwise `clkcount` <= `clkcount`+1.
- Channels are fully independent; `load` and `cnt_clr` are global.

## Timing
- **Reset (`rst_n` low, asynchronous):**
  - `ph` = 0, `rs` = DEFAULT_DIV.
  - `tick`, `clk_div`, `clkcount`, `cnt_sat` = 0.
  - Outputs change immediately on assertion. Release is sampled on the next rising edge.
- **First tick:** after `load` (or reset release) with `en` held high, `tick` rises on the Re-th enabled edge and repeats every Re enabled edges.
- **`clk_div`:** changes on the same edge that `tick` rises.
- **`clkcount` latency:** updates one edge after the `tick` it counts.
- **`busy` sampling:** `busy` is sampled in the cycle where `tick` = 1.
- **`en` dropped mid-period:** the phase is frozen, and the tick arrives late by exactly the number of disabled cycles.
- **Reset mid-period:** all state is discarded; `rs` reverts to DEFAULT_DIV, not to the last programmed ratio.
- **Wrap-around:** `ph` never exceeds Re-1. `clkcount` never wraps; it saturates.
- **Outputs:** all are registered; there is no combinational input-to-output path.

## Structure
- Shared package `clkdiv_pkg` holds:
  - the default widths (`DIV_W`, `CNT_W`) and `DEFAULT_DIV`;
  - a typedef for the ratio and counter words.
- Sub-module `clkdiv_chan` contains one channel: phase counter, shadow ratio, tick/`clk_div` and saturating counter.
- The top module is a generate loop over NCH that slices the packed buses and fans out `load` and `cnt_clr`.

## Test plan
- **Reset defaults:** reset, then `en`=1, `busy`=0 on both channels, no `load` → `tick` on edges 4, 8, 12; `clk_div` toggles 0→1→0 at the same edges; `clkcount` stays 0.
- **Mixed ratios:** ch0 R=3, ch1 R=1 via `load`, `en`=1, `busy`=1 for 30 cycles → ch0 gives 10 ticks and `clkcount`=10; ch1 gives `tick` constantly high and `clkcount`=30; R=0 on ch1 behaves identically to R=1.
- **Ratio change mid-period:** R=8 running, `div_ratio` switched to 2 at `ph`=3 → the current period still completes at 8 cycles, then ticks every 2.
- **`en` gap:** R=5, `en` deasserted for 3 cycles at `ph`=2 → the next tick arrives 8 cycles after the previous one and `clk_div` holds during the gap.
- **Saturation and clear:** CNT_W=4, R=1, `busy`=1 → `clkcount` reaches 15 and holds, `cnt_sat`=1; then `cnt_clr` asserted on a tick cycle → `clkcount`=0, `cnt_sat`=0.
- **Asynchronous reset mid-run:** `rst_n` pulsed between edges → outputs zero immediately; after release, the first tick arrives at edge 4.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared widths, reset ratio and word types for the multi-channel clock-enable generator.
package clkdiv_pkg;

  localparam int CLKDIV_DIV_W       = 16;
  localparam int CLKDIV_CNT_W       = 32;
  localparam int CLKDIV_DEFAULT_DIV = 4;

  typedef logic [CLKDIV_DIV_W-1:0] div_word_t;
  typedef logic [CLKDIV_CNT_W-1:0] cnt_word_t;

endpackage

// File: rtl/clkdiv_chan.sv
// One channel: phase counter with shadow ratio, tick / clk_div generation and a
// saturating busy-tick counter.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int DIV_W       = CLKDIV_DIV_W,
  parameter int CNT_W       = CLKDIV_CNT_W,
  parameter int DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             cnt_clr_i,
  input  logic             busy_i,
  input  logic [DIV_W-1:0] div_ratio_i,
  output logic             tick_o,
  output logic             clk_div_o,
  output logic [CNT_W-1:0] clkcount_o,
  output logic             cnt_sat_o
);

  logic [DIV_W-1:0] ph_q, ph_d;
  logic [DIV_W-1:0] rs_q, rs_d;
  logic             tick_q, tick_d;
  logic             clk_div_q, clk_div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [DIV_W-1:0] re;

  // A programmed ratio of zero behaves as divide-by-one.
  assign re = (rs_q == '0) ? DIV_W'(1) : rs_q;

  always_comb begin
    ph_d      = ph_q;
    rs_d      = rs_q;
    tick_d    = 1'b0;
    clk_div_d = clk_div_q;
    if (load_i) begin
      ph_d      = '0;
      clk_div_d = 1'b0;
      rs_d      = div_ratio_i;
    end else if (en_i) begin
      if (ph_q == re - DIV_W'(1)) begin
        ph_d      = '0;
        tick_d    = 1'b1;
        clk_div_d = ~clk_div_q;
        rs_d      = div_ratio_i;
      end else begin
        ph_d = ph_q + DIV_W'(1);
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (tick_q && busy_i) begin
      if (&cnt_q) sat_d = 1'b1;
      else        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ph_q      <= '0;
      rs_q      <= DIV_W'(DEFAULT_DIV);
      tick_q    <= 1'b0;
      clk_div_q <= 1'b0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      ph_q      <= ph_d;
      rs_q      <= rs_d;
      tick_q    <= tick_d;
      clk_div_q <= clk_div_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
    end
  end

  assign tick_o     = tick_q;
  assign clk_div_o  = clk_div_q;
  assign clkcount_o = cnt_q;
  assign cnt_sat_o  = sat_q;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock-enable generator; slices the packed buses
// and fans the global load / counter clear out to every channel.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int DIV_W       = CLKDIV_DIV_W,
  parameter int CNT_W       = CLKDIV_CNT_W,
  parameter int DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NCH-1:0]       en_i,
  input  logic [NCH*DIV_W-1:0] div_ratio_i,
  input  logic                 load_i,
  input  logic [NCH-1:0]       busy_i,
  input  logic                 cnt_clr_i,
  output logic [NCH-1:0]       tick_o,
  output logic [NCH-1:0]       clk_div_o,
  output logic [NCH*CNT_W-1:0] clkcount_o,
  output logic [NCH-1:0]       cnt_sat_o
);

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clkdiv_chan #(
      .DIV_W      (DIV_W),
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .en_i       (en_i[g]),
      .load_i     (load_i),
      .cnt_clr_i  (cnt_clr_i),
      .busy_i     (busy_i[g]),
      .div_ratio_i(div_ratio_i[g*DIV_W +: DIV_W]),
      .tick_o     (tick_o[g]),
      .clk_div_o  (clk_div_o[g]),
      .clkcount_o (clkcount_o[g*CNT_W +: CNT_W]),
      .cnt_sat_o  (cnt_sat_o[g])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed bench for clkdiv_multi: default-width instance plus a 4-bit-counter
// instance for saturation, both driven by the same stimulus.
module tb_clkdiv_multi;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [1:0]  en_i;
  logic [31:0] div_ratio_i;
  logic        load_i;
  logic [1:0]  busy_i;
  logic        cnt_clr_i;

  logic [1:0]  tick_o, clk_div_o, cnt_sat_o;
  logic [63:0] clkcount_o;
  logic [1:0]  tick4_o, clk_div4_o, cnt_sat4_o;
  logic [7:0]  clkcount4_o;

  int n_assert = 0;
  int n_fail   = 0;
  int n0, n1;

  always #5 clk_i = ~clk_i;

  clkdiv_multi dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .div_ratio_i(div_ratio_i),
    .load_i(load_i), .busy_i(busy_i), .cnt_clr_i(cnt_clr_i),
    .tick_o(tick_o), .clk_div_o(clk_div_o), .clkcount_o(clkcount_o), .cnt_sat_o(cnt_sat_o)
  );

  clkdiv_multi #(.CNT_W(4)) dut4 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .div_ratio_i(div_ratio_i),
    .load_i(load_i), .busy_i(busy_i), .cnt_clr_i(cnt_clr_i),
    .tick_o(tick4_o), .clk_div_o(clk_div4_o), .clkcount_o(clkcount4_o), .cnt_sat_o(cnt_sat4_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_n_i     = 1'b0;
    en_i        = 2'b11;
    busy_i      = 2'b00;
    load_i      = 1'b0;
    cnt_clr_i   = 1'b0;
    div_ratio_i = {16'd4, 16'd4};

    // reset state
    #2;
    chk("rst_tick", 64'(tick_o), 64'd0);
    chk("rst_clkdiv", 64'(clk_div_o), 64'd0);
    chk("rst_count", clkcount_o, 64'd0);
    chk("rst_sat", 64'(cnt_sat_o), 64'd0);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;

    // reset defaults: ticks at edges 4, 8, 12
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("dflt_tick", 64'(tick_o), (k % 4 == 0) ? 64'd3 : 64'd0);
      chk("dflt_clkdiv", 64'(clk_div_o), (k >= 4 && k < 8) || k >= 12 ? 64'd3 : 64'd0);
    end
    chk("dflt_count", clkcount_o, 64'd0);

    // mixed ratios: ch0 R=3, ch1 R=1, 30 busy cycles
    div_ratio_i = {16'd1, 16'd3};
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    busy_i = 2'b11;
    n0 = 0;
    n1 = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      chk("mix_tick0", 64'(tick_o[0]), (k % 3 == 0) ? 64'd1 : 64'd0);
      chk("mix_tick1", 64'(tick_o[1]), 64'd1);
      n0 += int'(tick_o[0]);
      n1 += int'(tick_o[1]);
    end
    en_i = 2'b00;
    step();
    busy_i = 2'b00;
    chk("mix_nticks0", 64'(n0), 64'd10);
    chk("mix_nticks1", 64'(n1), 64'd30);
    chk("mix_count0", 64'(clkcount_o[31:0]), 64'd10);
    chk("mix_count1", 64'(clkcount_o[63:32]), 64'd30);
    chk("mix_tick_off", 64'(tick_o), 64'd0);

    // R=0 on ch1 behaves as R=1
    div_ratio_i = {16'd0, 16'd3};
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    en_i = 2'b11;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("r0_tick1", 64'(tick_o[1]), 64'd1);
      chk("r0_clkdiv1", 64'(clk_div_o[1]), 64'(k % 2));
    end

    // ratio change mid-period: R=8, switched to 2 at ph=3
    div_ratio_i[15:0] = 16'd8;
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("rchg_tick0", 64'(tick_o[0]), (k == 8 || k == 10 || k == 12) ? 64'd1 : 64'd0);
      if (k == 3) div_ratio_i[15:0] = 16'd2;
    end

    // en gap: R=5, en low for 3 cycles at ph=2
    div_ratio_i[15:0] = 16'd5;
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      en_i[0] = !(k >= 8 && k <= 10);
      step();
      chk("gap_tick0", 64'(tick_o[0]), (k == 5 || k == 13) ? 64'd1 : 64'd0);
      chk("gap_clkdiv0", 64'(clk_div_o[0]), (k >= 5 && k < 13) ? 64'd1 : 64'd0);
    end
    en_i = 2'b11;

    // saturation on the 4-bit counter instance, then clear on a tick cycle
    busy_i = 2'b00;
    div_ratio_i = {16'd1, 16'd1};
    load_i = 1'b1;
    cnt_clr_i = 1'b1;
    step();
    load_i = 1'b0;
    cnt_clr_i = 1'b0;
    chk("sat_cleared", 64'(clkcount4_o[3:0]), 64'd0);
    busy_i = 2'b11;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 16) begin
        chk("sat_at15_cnt", 64'(clkcount4_o[3:0]), 64'd15);
        chk("sat_at15_flag", 64'(cnt_sat4_o[0]), 64'd0);
      end
    end
    chk("sat_hold_cnt", 64'(clkcount4_o[3:0]), 64'd15);
    chk("sat_hold_flag", 64'(cnt_sat4_o[0]), 64'd1);
    chk("sat_wide_cnt", 64'(clkcount_o[31:0]), 64'd19);
    chk("sat_wide_flag", 64'(cnt_sat_o[0]), 64'd0);
    cnt_clr_i = 1'b1;
    step();
    cnt_clr_i = 1'b0;
    chk("clr_on_tick", 64'(tick4_o[0]), 64'd1);
    chk("clr_cnt", 64'(clkcount4_o[3:0]), 64'd0);
    chk("clr_flag", 64'(cnt_sat4_o[0]), 64'd0);
    for (int k = 1; k <= 3; k++) step();
    chk("post_clr_cnt", 64'(clkcount_o[31:0]), 64'd3);

    // asynchronous reset between edges
    busy_i = 2'b00;
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("arst_tick", 64'(tick_o), 64'd0);
    chk("arst_clkdiv", 64'(clk_div_o), 64'd0);
    chk("arst_count", clkcount_o, 64'd0);
    chk("arst_sat4", 64'(cnt_sat4_o), 64'd0);
    div_ratio_i = {16'd7, 16'd7};
    rst_n_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("arst_first_tick", 64'(tick_o), (k == 4) ? 64'd3 : 64'd0);
      chk("arst_first_clkdiv", 64'(clk_div_o), (k >= 4) ? 64'd3 : 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
